// File: rtl/vram_pkg.sv
// Shared definitions for the banked sprite VRAM: default geometry and the
// clear-engine state encoding.
package vram_pkg;

    localparam int PIXEL_W_DEF = 16;
    localparam int BANKS_DEF   = 8;
    localparam int LINES_DEF   = 4096;

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_FILL = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_e;

endpackage

// File: rtl/vram_bank.sv
// One VRAM bank: simple dual-port block RAM with byte-enabled writes and a
// registered read port. Reads see the contents from before a same-edge write.
module vram_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam int unsigned NBYTE = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // byte-masked write port
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NBYTE; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vram_sprite_banked.sv
// Banked sprite VRAM: BANKS parallel word RAMs read as one line with 2-cycle
// latency, byte-enabled single-word writes, and an optional whole-memory
// clear engine compiled in with VRAM_SPRITE_CLEAR_EN.
module vram_sprite_banked
    import vram_pkg::*;
#(
    parameter  int PIXEL_W = PIXEL_W_DEF,
    parameter  int BANKS   = BANKS_DEF,
    parameter  int LINES   = LINES_DEF,
    localparam int LAW     = $clog2(LINES),
    localparam int BAW     = $clog2(BANKS),
    localparam int NBE     = PIXEL_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_req,
    input  logic [LAW-1:0]           rd_addr,
    output logic                     rd_valid,
    output logic [BANKS*PIXEL_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [LAW+BAW-1:0]       wr_addr,
    input  logic [PIXEL_W-1:0]       wr_data,
    input  logic [NBE-1:0]           wr_be,
    output logic                     wr_drop,
    input  logic                     clr_start,
    input  logic [PIXEL_W-1:0]       clr_value,
    output logic                     clr_busy,
    output logic                     clr_done
);

    logic [LAW-1:0]           wr_line;
    logic [BAW-1:0]           wr_bank;
    logic                     wr_ok;
    logic                     fill_we;
    logic [LAW-1:0]           fill_line;
    logic [PIXEL_W-1:0]       fill_word;
    logic [LAW-1:0]           bank_waddr;
    logic [PIXEL_W-1:0]       bank_wdata;
    logic [NBE-1:0]           bank_wbe;
    logic [BANKS*PIXEL_W-1:0] bank_q;
    logic                     rd_pend_q;

    // split the write address into line index and bank select
    always_comb begin
        wr_line = wr_addr[LAW+BAW-1:BAW];
        wr_bank = wr_addr[BAW-1:0];
    end

`ifdef VRAM_SPRITE_CLEAR_EN
    clr_state_e         state_q;
    clr_state_e         state_d;
    logic [LAW-1:0]     cnt_q;
    logic [PIXEL_W-1:0] clr_val_q;

    // clear state, line counter and fill word latched at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLR_IDLE;
            cnt_q     <= '0;
            clr_val_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLR_IDLE && clr_start) begin
                cnt_q     <= '0;
                clr_val_q <= clr_value;
            end else if (state_q == CLR_FILL) begin
                cnt_q <= cnt_q + LAW'(1);
            end
        end
    end

    // clear next-state and status outputs
    always_comb begin
        state_d  = state_q;
        fill_we  = 1'b0;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clr_start) begin
                    state_d = CLR_FILL;
                end
            end
            CLR_FILL: begin
                fill_we  = 1'b1;
                clr_busy = 1'b1;
                if (cnt_q == LAW'(LINES - 1)) begin
                    state_d = CLR_DONE;
                end
            end
            CLR_DONE: begin
                clr_busy = 1'b1;
                clr_done = 1'b1;
                state_d  = CLR_IDLE;
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    // fill writes the whole counter line with the latched word
    always_comb begin
        fill_line = cnt_q;
        fill_word = clr_val_q;
    end
`else
    logic unused_clr;

    // clear engine absent: no fill traffic, status tied off
    always_comb begin
        fill_we    = 1'b0;
        fill_line  = '0;
        fill_word  = '0;
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        unused_clr = ^{clr_start, clr_value};
    end
`endif

    // user writes lose to the clear engine for its whole busy window
    always_comb begin
        wr_ok      = wr_en & ~clr_busy;
        wr_drop    = wr_en & clr_busy;
        bank_waddr = fill_we ? fill_line : wr_line;
        bank_wdata = fill_we ? fill_word : wr_data;
        bank_wbe   = fill_we ? '1 : wr_be;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic bank_we;

        // fill hits every bank; a user write only hits its selected bank
        always_comb begin
            bank_we = fill_we | (wr_ok && (wr_bank == BAW'(b)));
        end

        vram_bank #(
            .DATA_W (PIXEL_W),
            .ADDR_W (LAW)
        ) u_bank (
            .clk     (clk),
            .we      (bank_we),
            .wr_addr (bank_waddr),
            .wr_data (bank_wdata),
            .wr_be   (bank_wbe),
            .rd_en   (rd_req),
            .rd_addr (rd_addr),
            .rd_data (bank_q[b*PIXEL_W +: PIXEL_W])
        );
    end

    // second read stage: capture the bank outputs, hold them between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_pend_q <= rd_req;
            rd_valid  <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data <= bank_q;
            end
        end
    end

endmodule

// File: tb/tb_vram_sprite_banked.sv
// Self-checking bench for vram_sprite_banked. Read expectations come from a
// bench-side memory model and are queued when a read is issued; clear-engine
// scenarios follow VRAM_SPRITE_CLEAR_EN.
module tb_vram_sprite_banked;

    localparam int PW  = 16;
    localparam int NB  = 8;
    localparam int NL  = 4096;
    localparam int LAW = 12;
    localparam int BAW = 3;

    logic             clk;
    logic             rst_n;
    logic             rd_req;
    logic [LAW-1:0]   rd_addr;
    logic             rd_valid;
    logic [NB*PW-1:0] rd_data;
    logic             wr_en;
    logic [LAW+BAW-1:0] wr_addr;
    logic [PW-1:0]    wr_data;
    logic [PW/8-1:0]  wr_be;
    logic             wr_drop;
    logic             clr_start;
    logic [PW-1:0]    clr_value;
    logic             clr_busy;
    logic             clr_done;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [NB*PW-1:0] data;
        int unsigned      cyc;
    } exp_t;

    exp_t             sbq[$];
    exp_t             mon_e;
    logic [NB*PW-1:0] last_data;
    logic [PW-1:0]    mdl [NL][NB];

    vram_sprite_banked #(
        .PIXEL_W (PW),
        .BANKS   (NB),
        .LINES   (NL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .wr_drop   (wr_drop),
        .clr_start (clr_start),
        .clr_value (clr_value),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every rd_valid pops one expected line and checks latency
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rd_valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: rd_valid=1 at cycle %0d, required no read outstanding", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    if (rd_data !== mon_e.data || cyc != mon_e.cyc + 2) begin
                        errors++;
                        $display("FAIL rd_line: got %h at cycle %0d, required %h at cycle %0d",
                                 rd_data, cyc, mon_e.data, mon_e.cyc + 2);
                    end
                    last_data = mon_e.data;
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [NB*PW-1:0] model_line(input int l);
        logic [NB*PW-1:0] v;
        for (int b = 0; b < NB; b++) v[b*PW +: PW] = mdl[l][b];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        rd_req    = 1'b0;
        wr_en     = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic set_read(input int l);
        exp_t e;
        rd_req  = 1'b1;
        rd_addr = LAW'(l);
        e.data  = model_line(l);
        e.cyc   = cyc;
        sbq.push_back(e);
    endtask

    task automatic set_write(input int l, input int b, input logic [PW-1:0] d,
                             input logic [PW/8-1:0] be, input bit commit);
        wr_en   = 1'b1;
        wr_addr = {LAW'(l), BAW'(b)};
        wr_data = d;
        wr_be   = be;
        if (commit) begin
            for (int k = 0; k < PW/8; k++) begin
                if (be[k]) mdl[l][b][k*8 +: 8] = d[k*8 +: 8];
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads still outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b, required 0", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h, required 0", rd_data); end
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %b, required 0", wr_drop); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b, required 0", clr_busy); end
        checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done: got %b, required 0", clr_done); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic init_lines();
        int lines[6] = '{5, 7, 10, 11, 12, 13};
        foreach (lines[j]) begin
            for (int b = 0; b < NB; b++) begin
                set_write(lines[j], b, PW'(lines[j] * 256 + b * 17 + 1), 2'b11, 1'b1);
                #1;
                checks++;
                if (wr_drop !== 1'b0) begin errors++; $display("FAIL init_wr_drop: got %b, required 0", wr_drop); end
                step();
            end
        end
    endtask

    task automatic test_write_read();
        set_write(5, 3, 16'hABCD, 2'b11, 1'b1);
        step();
        set_read(5);
        step();
        wait_drain();
    endtask

    task automatic test_byte_enable();
        set_write(5, 3, 16'h1234, 2'b01, 1'b1);
        step();
        set_read(5);
        step();
        set_write(5, 3, 16'h99EE, 2'b10, 1'b1);
        step();
        set_write(5, 3, 16'hFFFF, 2'b00, 1'b1);
        step();
        set_read(5);
        step();
        wait_drain();
    endtask

    task automatic test_read_first();
        set_read(7);
        set_write(7, 6, 16'h5555, 2'b11, 1'b1);
        step();
        set_read(7);
        step();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            set_read(10 + (i % 4));
            step();
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) set_read(10 + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) != 0)
                set_write(10 + int'($urandom_range(0, 3)), int'($urandom_range(0, NB - 1)),
                          PW'($urandom), 2'($urandom_range(0, 3)), 1'b1);
            step();
        end
        wait_drain();
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rd_valid !== 1'b0 || rd_data !== last_data) begin
                errors++;
                $display("FAIL hold: got valid=%b data=%h, required valid=0 data=%h", rd_valid, rd_data, last_data);
            end
        end
    endtask

    task automatic test_reset_inflight();
        set_read(5);
        step();
        set_read(7);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL inflight_reset: got valid=%b data=%h, required valid=0 data=0", rd_valid, rd_data);
        end
        sbq.delete();
        last_data = '0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rd_valid !== 1'b0) begin errors++; $display("FAIL inflight_drop: got rd_valid=%b, required 0", rd_valid); end
        end
    endtask

`ifdef VRAM_SPRITE_CLEAR_EN
    // mode 0: full clear scenario with dropped writes, ignored restart and
    // reads during fill; mode 1: restart check reading line 0 in fill cycles 0 and 1
    task automatic run_fill(input logic [PW-1:0] val, input int mode,
                            output int busy_n, output int done_n, output int done_at);
        busy_n = 0; done_n = 0; done_at = -1;
        clr_value = val;
        clr_start = 1'b1;
        step();
        clr_value = ~val;
        for (int i = 0; i < NL + 8; i++) begin
            if (clr_busy !== 1'b1) break;
            busy_n++;
            if (clr_done === 1'b1) begin done_n++; done_at = i; end
            if (mode == 0) begin
                if (i == 10) clr_start = 1'b1;
                if (i == 50) set_read(0);
                if (i == 51) set_read(NL - 1);
                if (i == 40 || i == NL) begin
                    set_write((i == 40) ? 2 : 3, 1, 16'hDEAD, 2'b11, 1'b0);
                    #1;
                    checks++;
                    if (wr_drop !== 1'b1) begin errors++; $display("FAIL fill_wr_drop: fill cycle %0d got %b, required 1", i, wr_drop); end
                end
            end else if (i <= 1) begin
                set_read(0);
            end
            if (i < NL) for (int b = 0; b < NB; b++) mdl[i][b] = val;
            step();
        end
    endtask

    task automatic test_clear();
        int busy_n, done_n, done_at;
        for (int b = 0; b < NB; b++) begin
            set_write(NL - 1, b, PW'(16'hC000 + b), 2'b11, 1'b1);
            step();
        end
        run_fill(16'h0F0F, 0, busy_n, done_n, done_at);
        checks++; if (busy_n != NL + 1) begin errors++; $display("FAIL clr_busy_len: got %0d cycles, required %0d", busy_n, NL + 1); end
        checks++; if (done_n != 1 || done_at != NL) begin errors++; $display("FAIL clr_done_pulse: got %0d pulses at cycle %0d, required 1 at %0d", done_n, done_at, NL); end
        checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL clr_idle: got busy=%b done=%b, required 0 0", clr_busy, clr_done); end
        set_write(3, 2, 16'h1357, 2'b11, 1'b1);
        #1;
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL post_clear_wr_drop: got %b, required 0", wr_drop); end
        step();
        for (int l = 0; l < NL; l++) begin
            set_read(l);
            step();
        end
        wait_drain();
    endtask

    task automatic test_reset_abort();
        int busy_n, done_n, done_at;
        clr_value = 16'h3C3C;
        clr_start = 1'b1;
        step();
        for (int i = 0; i < 100; i++) begin
            for (int b = 0; b < NB; b++) mdl[i][b] = 16'h3C3C;
            step();
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b done=%b, required 0 0", clr_busy, clr_done);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle: got busy=%b done=%b, required 0 0", clr_busy, clr_done);
            end
        end
        run_fill(16'h7E7E, 1, busy_n, done_n, done_at);
        wait_drain();
        checks++; if (busy_n != NL + 1) begin errors++; $display("FAIL restart_busy_len: got %0d cycles, required %0d", busy_n, NL + 1); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL restart_done: got %0d pulses, required 1", done_n); end
    endtask
`else
    task automatic test_clear_disabled();
        clr_value = 16'h0F0F;
        clr_start = 1'b1;
        set_write(5, 0, 16'h2468, 2'b11, 1'b1);
        #1;
        checks++;
        if (wr_drop !== 1'b0 || clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL nclr_start: got drop=%b busy=%b, required 0 0", wr_drop, clr_busy);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) set_write(5, 1, 16'h8642, 2'b11, 1'b1);
            #1;
            checks++;
            if (clr_busy !== 1'b0 || clr_done !== 1'b0 || wr_drop !== 1'b0) begin
                errors++;
                $display("FAIL nclr_idle: got busy=%b done=%b drop=%b, required 0 0 0", clr_busy, clr_done, wr_drop);
            end
            step();
        end
        set_read(5);
        step();
        wait_drain();
    endtask
`endif

    initial begin : main
        rst_n     = 1'b1;
        rd_req    = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_be     = '0;
        clr_start = 1'b0;
        clr_value = '0;
        last_data = '0;
        for (int l = 0; l < NL; l++)
            for (int b = 0; b < NB; b++) mdl[l][b] = '0;
        #2 rst_n = 1'b0;

        test_reset();
        init_lines();
        test_write_read();
        test_byte_enable();
        test_read_first();
        test_back_to_back();
        test_hold();
        test_reset_inflight();
`ifdef VRAM_SPRITE_CLEAR_EN
        test_clear();
        test_reset_abort();
`else
        test_clear_disabled();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
